// File: rtl/log_dumper_pkg.sv
// Shared types and constants for the switch-activity log dumper.
// LOG_DUMP_FOOTER_EN adds the FOOTER state to the state enum.
package log_dumper_pkg;

   localparam int DATA_WIDTH = 32;

   typedef struct packed {
      logic [DATA_WIDTH-3:0] ts;
      logic                  sw1;
      logic                  sw0;
   } log_file_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_POP,
      ST_LATCH,
      ST_TS_HEX,
      ST_SPACE,
      ST_SW1,
      ST_SW0,
      ST_CR,
`ifdef LOG_DUMP_FOOTER_EN
      ST_LF,
      ST_FOOTER
`else
      ST_LF
`endif
   } dump_state_t;

   localparam logic [7:0] ASCII_SP   = 8'h20;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;

   // States in which a byte is presented on the UART side
   function automatic logic is_emit(dump_state_t s);
      logic e;
      e = (s == ST_TS_HEX) || (s == ST_SPACE) || (s == ST_SW1) ||
          (s == ST_SW0) || (s == ST_CR) || (s == ST_LF);
`ifdef LOG_DUMP_FOOTER_EN
      e = e || (s == ST_FOOTER);
`endif
      return e;
   endfunction

endpackage

// File: rtl/log_dumper_hex_ascii.sv
// Nibble to uppercase ASCII hex character.
// Shared by the timestamp and footer digit paths.
module hex_ascii
   import log_dumper_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_0 + {4'h0, nibble};
      end else begin
         ascii = ASCII_A + ({4'h0, nibble} - 8'd10);
      end
   end

endmodule

// File: rtl/log_dumper.sv
// Pops log records from the FIFO and prints them as ASCII lines to the UART.
// Define LOG_DUMP_FOOTER_EN to append a "#NNNN" record-count footer per session.
module log_dumper #(
   parameter int DATA_WIDTH = log_dumper_pkg::DATA_WIDTH,
   parameter int TS_DIGITS  = (DATA_WIDTH - 2 + 3) / 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dump_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy
);
   import log_dumper_pkg::*;

   localparam int TSW = TS_DIGITS * 4;
   localparam int IW  = (TS_DIGITS > 1) ? $clog2(TS_DIGITS) : 1;

   dump_state_t           state_q, state_d;
   logic [IW-1:0]         dig_q, dig_d;
   logic [DATA_WIDTH-1:0] rec_q, rec_d;
   logic                  fifo_rd_q, fifo_rd_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  busy_q, busy_d;

   logic                  xfer;
   logic                  more;
   logic [TSW-1:0]        ts_pad;
   logic [3:0]            nib;
   logic [7:0]            hex_chr;
   logic [7:0]            byte_nxt;

`ifdef LOG_DUMP_FOOTER_EN
   logic [15:0]           cnt_q, cnt_d;
   logic [2:0]            ft_q, ft_d;
   logic                  en_q, en_d;
   logic                  done_q, done_d;
   logic                  footer_go;
`endif

   assign xfer = tx_valid_q && tx_ready;
   assign more = dump_en && !fifo_empty;

`ifdef LOG_DUMP_FOOTER_EN
   assign footer_go = dump_en && fifo_empty && !done_q;

   always_comb begin
      en_d   = dump_en;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (dump_en && !en_q) begin
         cnt_d = 16'h0000;
      end else if (state_q == ST_LF && xfer && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
      // A session ends when dump_en drops; that re-arms the footer
      if (!dump_en) begin
         done_d = 1'b0;
      end else if (state_q == ST_FOOTER && xfer && ft_q == 3'd6) begin
         done_d = 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      rec_d   = rec_q;
`ifdef LOG_DUMP_FOOTER_EN
      ft_d    = ft_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (more) begin
               state_d = ST_POP;
            end
`ifdef LOG_DUMP_FOOTER_EN
            else if (footer_go) begin
               state_d = ST_FOOTER;
               ft_d    = 3'd0;
            end
`endif
         end
         ST_POP: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            rec_d   = fifo_rd_data;
            dig_d   = '0;
            state_d = ST_TS_HEX;
         end
         ST_TS_HEX: begin
            if (xfer) begin
               if (dig_q == IW'(TS_DIGITS - 1)) begin
                  state_d = ST_SPACE;
               end else begin
                  dig_d = dig_q + IW'(1);
               end
            end
         end
         ST_SPACE: if (xfer) state_d = ST_SW1;
         ST_SW1:   if (xfer) state_d = ST_SW0;
         ST_SW0:   if (xfer) state_d = ST_CR;
         ST_CR:    if (xfer) state_d = ST_LF;
         ST_LF: begin
            if (xfer) begin
               if (more) begin
                  state_d = ST_POP;
               end
`ifdef LOG_DUMP_FOOTER_EN
               else if (footer_go) begin
                  state_d = ST_FOOTER;
                  ft_d    = 3'd0;
               end
`endif
               else begin
                  state_d = ST_IDLE;
               end
            end
         end
`ifdef LOG_DUMP_FOOTER_EN
         ST_FOOTER: begin
            if (xfer) begin
               if (ft_q == 3'd6) begin
                  state_d = ST_IDLE;
               end else begin
                  ft_d = ft_q + 3'd1;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Byte for the next cycle is built from next-state values so outputs stay registered
   always_comb begin
      ts_pad = TSW'(rec_d[DATA_WIDTH-1:2]);
      nib    = 4'(ts_pad >> (4 * (TS_DIGITS - 1 - int'(dig_d))));
`ifdef LOG_DUMP_FOOTER_EN
      if (state_d == ST_FOOTER) begin
         case (ft_d)
            3'd1:    nib = cnt_q[15:12];
            3'd2:    nib = cnt_q[11:8];
            3'd3:    nib = cnt_q[7:4];
            default: nib = cnt_q[3:0];
         endcase
      end
`endif
   end

   hex_ascii u_hex (
      .nibble (nib),
      .ascii  (hex_chr)
   );

   always_comb begin
      byte_nxt = 8'h00;
      case (state_d)
         ST_TS_HEX: byte_nxt = hex_chr;
         ST_SPACE:  byte_nxt = ASCII_SP;
         ST_SW1:    byte_nxt = ASCII_0 | {7'd0, rec_d[1]};
         ST_SW0:    byte_nxt = ASCII_0 | {7'd0, rec_d[0]};
         ST_CR:     byte_nxt = ASCII_CR;
         ST_LF:     byte_nxt = ASCII_LF;
`ifdef LOG_DUMP_FOOTER_EN
         ST_FOOTER: begin
            case (ft_d)
               3'd0:    byte_nxt = ASCII_HASH;
               3'd5:    byte_nxt = ASCII_CR;
               3'd6:    byte_nxt = ASCII_LF;
               default: byte_nxt = hex_chr;
            endcase
         end
`endif
         default:   byte_nxt = 8'h00;
      endcase
   end

   always_comb begin
      fifo_rd_d  = (state_d == ST_POP);
      busy_d     = (state_d != ST_IDLE);
      tx_valid_d = is_emit(state_d);
      if (tx_valid_q && !tx_ready) begin
         tx_data_d = tx_data_q;
      end else begin
         tx_data_d = byte_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         dig_q      <= '0;
         rec_q      <= '0;
         fifo_rd_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dig_q      <= dig_d;
         rec_q      <= rec_d;
         fifo_rd_q  <= fifo_rd_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

`ifdef LOG_DUMP_FOOTER_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 16'h0000;
         ft_q   <= 3'd0;
         en_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ft_q   <= ft_d;
         en_q   <= en_d;
         done_q <= done_d;
      end
   end
`endif

   assign fifo_rd  = fifo_rd_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_log_dumper.sv
// Scoreboard bench for log_dumper: FIFO model, byte monitor, reference line model.
// Footer expectations follow LOG_DUMP_FOOTER_EN.
module tb_log_dumper;
   import log_dumper_pkg::*;

`ifdef LOG_DUMP_FOOTER_EN
   localparam bit FTR = 1'b1;
`else
   localparam bit FTR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dump_en = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_rd_data = 32'h0;
   logic        fifo_rd;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   logic        rand_mode = 1'b0;
   logic        ready_force = 1'b1;
   logic        rnd_ready = 1'b1;

   int          tests = 0;
   int          fails = 0;
   int          pops = 0;
   int          rx_cnt = 0;
   logic        prev_rd = 1'b0;
   logic        stall_q = 1'b0;
   logic [7:0]  stall_data = 8'h00;

   logic [31:0] fifo_q[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   assign tx_ready = rand_mode ? rnd_ready : ready_force;

   log_dumper #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dump_en      (dump_en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd      (fifo_rd),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // FIFO with registered read data
   always @(posedge clk) begin
      if (rst_n && fifo_rd) begin
         chk("pop_nonempty", 32'(fifo_q.size() != 0), 1);
         chk("rd_single_pulse", 32'(prev_rd), 0);
         if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
         pops++;
         fifo_empty <= (fifo_q.size() == 0);
      end
      prev_rd = fifo_rd;
   end

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor: a byte is transferred on the next rising edge when valid && ready here
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", 32'(tx_valid), 1);
            chk("hold_data", 32'(tx_data), 32'(stall_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_byte: got %0h, expected no byte", tx_data);
            end else begin
               chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            rx_cnt++;
         end
         stall_q = tx_valid && !tx_ready;
         stall_data = tx_data;
      end
   end

   function automatic logic [7:0] hexc(input int v);
      return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
   endfunction

   task automatic push_line(input logic [31:0] w);
      int ts;
      ts = int'(w >> 2);
      for (int d = 7; d >= 0; d--) exp_q.push_back(hexc((ts >> (4 * d)) & 15));
      exp_q.push_back(8'h20);
      exp_q.push_back(w[1] ? 8'h31 : 8'h30);
      exp_q.push_back(w[0] ? 8'h31 : 8'h30);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic push_footer(input int n);
      if (FTR) begin
         exp_q.push_back(8'h23);
         for (int d = 3; d >= 0; d--) exp_q.push_back(hexc((n >> (4 * d)) & 15));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic fifo_add(input logic [31:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic push_rec(input logic [31:0] w);
      fifo_add(w);
      push_line(w);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         step();
         if (!busy && exp_q.size() == 0) break;
      end
      chk(name, 32'(i < budget), 1);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (rx_cnt >= n) break;
         step();
      end
      chk("wait_rx_in_time", 32'(i < budget), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, rxb, cnt, n, i;
      logic [31:0] w;

      repeat (3) step();
      chk("rst_fifo_rd", 32'(fifo_rd), 0);
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      step();

      // basic record and latency
      push_rec({30'h0A5, 2'b10});
      push_footer(1);
      base = pops;
      dump_en = 1'b1;
      step();
      chk("lat_rd_hi", 32'(fifo_rd), 1);
      chk("lat_busy", 32'(busy), 1);
      step();
      chk("lat_rd_lo", 32'(fifo_rd), 0);
      chk("lat_valid_lo", 32'(tx_valid), 0);
      step();
      chk("lat_valid_hi", 32'(tx_valid), 1);
      chk("lat_first_byte", 32'(tx_data), 32'h30);
      wait_done("basic_done", 200);
      chk("basic_pops", 32'(pops - base), 1);
      dump_en = 1'b0;
      repeat (2) step();

      // backpressure on 'A'
      push_rec({30'h0A5, 2'b10});
      push_footer(1);
      base = pops;
      rxb = rx_cnt;
      dump_en = 1'b1;
      wait_rx(rxb + 6, 100);
      ready_force = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(tx_valid), 1);
         chk("bp_data", 32'(tx_data), 32'h41);
      end
      step();
      ready_force = 1'b1;
      wait_done("bp_done", 200);
      chk("bp_pops", 32'(pops - base), 1);
      dump_en = 1'b0;
      repeat (2) step();

      // empty FIFO
      push_footer(0);
      base = pops;
      rxb = rx_cnt;
      dump_en = 1'b1;
      repeat (20) step();
      chk("empty_pops", 32'(pops - base), 0);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_bytes", 32'(rx_cnt - rxb), FTR ? 7 : 0);
      dump_en = 1'b0;
      repeat (2) step();

      // early stop during the 2nd timestamp digit
      w = $urandom;
      fifo_add(w);
      push_line(w);
      fifo_add($urandom);
      fifo_add($urandom);
      base = pops;
      rxb = rx_cnt;
      dump_en = 1'b1;
      wait_rx(rxb + 1, 100);
      dump_en = 1'b0;
      wait_done("early_done", 200);
      repeat (5) step();
      chk("early_pops", 32'(pops - base), 1);
      chk("early_busy", 32'(busy), 0);
      fifo_q.delete();
      fifo_empty = 1'b1;
      step();

      // asynchronous reset during SW1
      push_rec($urandom);
      push_rec($urandom);
      base = pops;
      rxb = rx_cnt;
      dump_en = 1'b1;
      wait_rx(rxb + 9, 100);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(tx_valid), 0);
      chk("arst_rd", 32'(fifo_rd), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_data", 32'(tx_data), 0);
      exp_q.delete();
      push_line(fifo_q[0]);
      push_footer(1);
      repeat (2) step();
      rst_n = 1'b1;
      wait_done("arst_done", 200);
      chk("arst_pops", 32'(pops - base), 2);
      chk("arst_fifo_drained", 32'(fifo_q.size()), 0);
      dump_en = 1'b0;
      repeat (2) step();

      // three fixed records, throughput and footer count
      push_rec({30'h1, 2'b01});
      push_rec({30'h2, 2'b11});
      push_rec({30'h3F, 2'b00});
      push_footer(3);
      base = pops;
      cnt = 0;
      dump_en = 1'b1;
      for (i = 0; i < 300; i++) begin
         step();
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
      chk("thru_in_time", 32'(i < 300), 1);
      chk("thru_busy_cycles", 32'(cnt), FTR ? 52 : 45);
      repeat (20) step();
      chk("three_pops", 32'(pops - base), 3);
      chk("three_drained", 32'(exp_q.size()), 0);
      dump_en = 1'b0;
      repeat (2) step();

      // randomized sessions with random backpressure
      rand_mode = 1'b1;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 5);
         for (int r = 0; r < n; r++) push_rec($urandom);
         push_footer(n);
         base = pops;
         dump_en = 1'b1;
         wait_done("rand_done", 2000);
         repeat (10) step();
         chk("rand_pops", 32'(pops - base), 32'(n));
         dump_en = 1'b0;
         repeat (2) step();
      end
      rand_mode = 1'b0;
      repeat (5) step();

      chk("final_exp_drained", 32'(exp_q.size()), 0);
      chk("final_idle", 32'(busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/log_dumper.md
# log_dumper

Read side of the switch-activity log. While the logger is in DUMP, this block pops `log_file_t` records from the log FIFO and sends each one as a printable ASCII line to the UART transmitter. Each line contains a hex timestamp and the two switch bits. The block sits between the FIFO read port and the UART TX byte interface, and is driven by the logger's `read_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: FIFO word width. Bits `[DATA_WIDTH-1:2]` are the timestamp, bit 1 is switch1, bit 0 is switch0.
- `TS_DIGITS`, default `(DATA_WIDTH-2+3)/4`: number of hex digits printed for the timestamp.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dump_en` in 1: dump request (logger `read_en`). Level-sensitive.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_data` in `DATA_WIDTH`: FIFO read data, valid the cycle after `fifo_rd`.
- `fifo_rd` out 1: FIFO pop, a single-cycle pulse.
- `tx_data` out 8: ASCII byte to the UART.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: UART accepts a byte.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, POP, LATCH, TS_HEX, SPACE, SW1, SW0, CR, LF, plus FOOTER when the footer feature is compiled in.
- **IDLE → POP:** taken when `dump_en && !fifo_empty`. `fifo_rd` is 1 for exactly the POP cycle.
- **LATCH:** `fifo_rd_data` is registered into the record register. Next state is TS_HEX.
- **TS_HEX:** emits `TS_DIGITS` hex characters, most significant nibble first. Digits are uppercase (`0-9`, `A-F`). The top nibble is zero-padded.
- **Line layout:** SPACE emits 0x20. SW1 and SW0 emit `'0'` or `'1'`. CR emits 0x0D and LF emits 0x0A. For `DATA_WIDTH`=32 a record is 13 bytes.
- **After LF:**
  - Go to POP if `dump_en && !fifo_empty`.
  - Otherwise go to IDLE (or FOOTER, see Configuration).
- **`dump_en` falling mid-record:** the current line always completes. No further `fifo_rd` is issued.
- **Empty FIFO with `dump_en` high:** stay in IDLE. `fifo_rd` never asserts while `fifo_empty`=1.
- **Simultaneous `fifo_empty` and `dump_en` rise:** treated as empty. Nothing is popped.
- **Asynchronous reset mid-record:** all outputs go to 0 immediately and the partial line is abandoned. After release the block is in IDLE.

## Timing
- **Reset values:** `fifo_rd`=0, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, state=IDLE, record register=0, digit index=0.
- **Handshake:**
  - A byte transfers on a rising edge where `tx_valid && tx_ready`.
  - Once asserted, `tx_valid` and `tx_data` hold stable until that transfer.
  - The next byte is presented in the cycle after the transfer. Back-to-back bytes are allowed when `tx_ready` is held high.
- **Latency:** with the pop condition true at edge k, `fifo_rd` is high in cycle k+1, data is latched at edge k+2, and the first `tx_valid` is high in cycle k+3.
- **Throughput:** 13 bytes plus a 2-cycle pop overhead per record (`DATA_WIDTH`=32, `tx_ready`=1).
- **Outputs:** all registered. There is no combinational path from `tx_ready` to `tx_valid`.
- **Digit index:** counts 0..`TS_DIGITS`-1 with no wrap. It resets to 0 on entry to TS_HEX.

## Configuration
- **`LOG_DUMP_FOOTER_EN` defined:**
  - A 16-bit record counter is cleared on the `dump_en` rising edge. It increments at each LF transfer and saturates at 16'hFFFF.
  - When a session has `dump_en` high and `fifo_empty` is seen in IDLE or after LF, FOOTER emits `'#'`, 4 uppercase hex digits of the count, then CR LF.
  - The footer is sent once per session. A session ends when `dump_en` goes low.
  - If `dump_en` falls before the FIFO empties, no footer is sent.
- **Undefined:** no counter and no FOOTER state. The block goes idle silently when the FIFO is empty.

## Structure
- **Shared package:** `log_file_t`, `DATA_WIDTH`, `dump_state_t` enum, ASCII constants (`ASCII_SP`, `ASCII_CR`, `ASCII_LF`, `ASCII_HASH`, `ASCII_0`).
- **Sub-module `hex_ascii`:** combinational, 4-bit nibble → 8-bit uppercase ASCII. Shared by TS_HEX and FOOTER.

## Test plan
- **Basic record:** FIFO holds `{30'h0A5, 1'b1, 1'b0}`, `dump_en`=1, `tx_ready`=1 → bytes `"000000A5 10\r\n"`, exactly one `fifo_rd` pulse, first `tx_valid` 3 cycles after `dump_en`.
- **Backpressure:** `tx_ready` dropped for 5 cycles while `'A'` is presented → `tx_data`=0x41 and `tx_valid` held stable, no bytes lost or duplicated, the line still completes correctly.
- **Empty FIFO:** `dump_en`=1, `fifo_empty`=1 → no `fifo_rd`, no `tx_valid`. With the footer compiled in → `"#0000\r\n"` once.
- **Early stop:** 3 records queued, `dump_en` drops during the 2nd timestamp digit of record 1 → record 1 completes through LF, `fifo_rd` pulses once in total, `busy`=0 afterwards.
- **Reset mid-record:** `rst_n` low during SW1 → `tx_valid`=0 and `fifo_rd`=0 within the same cycle, without waiting for a clock edge. After release with `dump_en`=1, the next line starts from the FIFO head with no partial bytes.
- **Footer count** (`LOG_DUMP_FOOTER_EN`): 3 records `{30'h1,2'b01}`, `{30'h2,2'b11}`, `{30'h3F,2'b00}` → 3 lines, then `"#0003\r\n"` exactly once while `dump_en` stays high.
